// File: rtl/register_file_sb.sv
// Register array with pending-write scoreboard between ID and WB.
// Define REGFILE_BYPASS_EN to forward same-cycle WB data to the read ports.
module register_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] SRC,
    output logic [NUM_RD*DATA_W-1:0] REG,
    output logic [NUM_RD-1:0]        HAZARD,
    input  logic                     WB_EN,
    input  logic [ADDR_W-1:0]        DEST_WB,
    input  logic [DATA_W-1:0]        RESULT_WB,
    input  logic                     ISSUE_EN,
    input  logic [ADDR_W-1:0]        DEST_ISSUE,
    input  logic                     FLUSH,
    output logic [ADDR_W:0]          PENDING_CNT
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              set_new;
    logic              clr_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (WB_EN) begin
            mem[DEST_WB] <= RESULT_WB;
        end
    end

    // A same-register issue keeps the mark, so the WB clear must not count.
    assign set_new = ISSUE_EN && !pend[DEST_ISSUE];
    assign clr_old = WB_EN && pend[DEST_WB]
                     && !(ISSUE_EN && (DEST_ISSUE == DEST_WB));

    always_comb begin
        pend_nxt = pend;
        cnt_nxt  = cnt;
        unique case (1'b1)
            FLUSH: begin
                pend_nxt = '0;
                cnt_nxt  = '0;
            end
            default: begin
                if (WB_EN) begin
                    pend_nxt[DEST_WB] = 1'b0;
                end
                if (ISSUE_EN) begin
                    pend_nxt[DEST_ISSUE] = 1'b1;
                end
                cnt_nxt = cnt + CW'(set_new) - CW'(clr_old);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
        end
    end

    assign PENDING_CNT = cnt;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] src;
        logic [DATA_W-1:0] rd;
        logic              hz;

        assign src = SRC[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[src];
            hz = pend[src];
`ifdef REGFILE_BYPASS_EN
            if (WB_EN && (DEST_WB == src)) begin
                rd = RESULT_WB;
                if (!(ISSUE_EN && (DEST_ISSUE == src))) begin
                    hz = 1'b0;
                end
            end
`endif
        end

        assign REG[i*DATA_W +: DATA_W] = rd;
        assign HAZARD[i]               = hz;
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb with three read ports.
// Expectations follow the bypass macro when it is defined.
module tb_register_file_sb;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 3;

    logic            clk;
    logic            rst_n;
    logic [NR*AW-1:0] src;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]   hazard;
    logic            wb_en;
    logic [AW-1:0]   dest_wb;
    logic [DW-1:0]   result_wb;
    logic            issue_en;
    logic [AW-1:0]   dest_issue;
    logic            flush;
    logic [AW:0]     pcnt;

    int checks   = 0;
    int failures = 0;

    register_file_sb #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .NUM_RD(NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SRC        (src),
        .REG        (rdata),
        .HAZARD     (hazard),
        .WB_EN      (wb_en),
        .DEST_WB    (dest_wb),
        .RESULT_WB  (result_wb),
        .ISSUE_EN   (issue_en),
        .DEST_ISSUE (dest_issue),
        .FLUSH      (flush),
        .PENDING_CNT(pcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] c);
        src = {c, b, a};
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rdata[p*DW +: DW];
    endfunction

    task automatic idle();
        wb_en    = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_wb(input logic [AW-1:0] r, input logic [DW-1:0] d);
        wb_en     = 1'b1;
        dest_wb   = r;
        result_wb = d;
    endtask

    task automatic do_issue(input logic [AW-1:0] r);
        issue_en   = 1'b1;
        dest_issue = r;
    endtask

    initial begin
        rst_n      = 1'b0;
        src        = '0;
        wb_en      = 1'b0;
        dest_wb    = '0;
        result_wb  = '0;
        issue_en   = 1'b0;
        dest_issue = '0;
        flush      = 1'b0;
        tick();
        tick();
        set_src(4'd0, 4'd5, 4'd15);
        #1;
        check("rst_reg0", rd(0), 0);
        check("rst_haz", hazard, 0);
        check("rst_cnt", pcnt, 0);
        #3 rst_n = 1'b1;
        tick();

        // reset asserted mid-operation
        do_wb(4'd3, 32'hDEADBEEF);
        tick();
        idle();
        do_issue(4'd5);
        tick();
        idle();
        set_src(4'd5, 4'd3, 4'd3);
        #1;
        check("pre_rst_r3", rd(1), 32'hDEADBEEF);
        check("pre_rst_haz", hazard, 3'b001);
        check("pre_rst_cnt", pcnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_r5", rd(0), 0);
        check("mid_rst_r3", rd(1), 0);
        check("mid_rst_haz", hazard, 0);
        check("mid_rst_cnt", pcnt, 0);
        #1 rst_n = 1'b1;
        tick();

        // write then read across aliased ports
        do_wb(4'd1, 32'h11);
        tick();
        do_wb(4'd2, 32'h22);
        tick();
        idle();
        set_src(4'd1, 4'd2, 4'd1);
        #1;
        check("rd_p0", rd(0), 32'h11);
        check("rd_p1", rd(1), 32'h22);
        check("rd_p2", rd(2), 32'h11);
        check("rd_haz", hazard, 0);

        // issue -> hazard -> wb
        set_src(4'd4, 4'd0, 4'd0);
        do_issue(4'd4);
        tick();
        idle();
        #1;
        check("sb_haz_c1", hazard[0], 1'b1);
        check("sb_cnt_c1", pcnt, 1);
        check("sb_reg_c1", rd(0), 0);
        tick();
        tick();
        do_wb(4'd4, 32'h44);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("sb_reg_c3", rd(0), 32'h44);
        check("sb_haz_c3", hazard[0], 1'b0);
`else
        check("sb_reg_c3", rd(0), 0);
        check("sb_haz_c3", hazard[0], 1'b1);
`endif
        check("sb_cnt_c3", pcnt, 1);
        tick();
        idle();
        #1;
        check("sb_reg_c4", rd(0), 32'h44);
        check("sb_haz_c4", hazard[0], 1'b0);
        check("sb_cnt_c4", pcnt, 0);

        // same-cycle issue and wb of R7 with R7 already pending
        do_issue(4'd7);
        tick();
        idle();
        do_issue(4'd7);
        do_wb(4'd7, 32'h77);
        set_src(4'd7, 4'd0, 4'd0);
        #1;
        check("iw_haz_same", hazard[0], 1'b1);
        tick();
        idle();
        #1;
        check("iw_reg", rd(0), 32'h77);
        check("iw_haz", hazard[0], 1'b1);
        check("iw_cnt", pcnt, 1);
        do_wb(4'd7, 32'h78);
        tick();
        idle();
        // wb to a non-pending register leaves the count alone
        do_wb(4'd6, 32'h66);
        tick();
        idle();
        set_src(4'd7, 4'd6, 4'd0);
        #1;
        check("nonpend_cnt", pcnt, 0);
        check("nonpend_reg", rd(1), 32'h66);
        check("wb7_reg", rd(0), 32'h78);

        // flush
        do_issue(4'd1);
        tick();
        do_issue(4'd2);
        tick();
        do_issue(4'd3);
        tick();
        idle();
        #1;
        check("fl_cnt3", pcnt, 3);
        flush = 1'b1;
        do_issue(4'd9);
        do_wb(4'd2, 32'h5);
        tick();
        idle();
        set_src(4'd1, 4'd2, 4'd9);
        #1;
        check("fl_cnt", pcnt, 0);
        check("fl_haz", hazard, 0);
        check("fl_r2", rd(1), 32'h5);
        set_src(4'd3, 4'd3, 4'd3);
        #1;
        check("fl_haz3", hazard, 0);

        // fill the scoreboard, then drain
        for (int r = 0; r < 16; r++) begin
            do_issue(AW'(r));
            tick();
        end
        idle();
        #1;
        check("full_cnt", pcnt, 16);
        set_src(4'd0, 4'd8, 4'd15);
        #1;
        check("full_haz", hazard, 3'b111);
        do_issue(4'd0);
        tick();
        idle();
        #1;
        check("full_reissue", pcnt, 16);
        for (int r = 0; r < 16; r++) begin
            do_wb(AW'(r), 32'h100 + r);
            tick();
            idle();
            #1;
            check($sformatf("drain_%0d", r), pcnt, 15 - r);
        end
        set_src(4'd0, 4'd8, 4'd15);
        #1;
        check("drain_haz", hazard, 0);
        check("drain_r8", rd(1), 32'h108);
        check("drain_r15", rd(2), 32'h10F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the core's 16×32 register file: a multi-read-port, single-write-port register array with an integrated pending-write scoreboard. It sits between the ID stage (read ports, issue marking) and the WB stage (write port, pending clear). It reports per-port read-after-write hazards to the hazard unit and supports a pipeline flush of outstanding pending marks.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (≥1)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- SRC  in  NUM_RD*ADDR_W  read indices; port i = bits [i*ADDR_W +: ADDR_W]
- REG  out  NUM_RD*DATA_W  read data, packed like SRC
- HAZARD  out  NUM_RD  port i's source has an outstanding write
- WB_EN  in  1  write enable
- DEST_WB  in  ADDR_W  write index
- RESULT_WB  in  DATA_W  write data
- ISSUE_EN  in  1  mark DEST_ISSUE as pending
- DEST_ISSUE  in  ADDR_W  index of the register a newly issued instruction will write
- FLUSH  in  1  clear all pending marks
- PENDING_CNT  out  ADDR_W+1  number of registers currently marked pending

## Operation
- Storage: 2**ADDR_W × DATA_W array plus 2**ADDR_W pending bits; PENDING_CNT is a registered counter kept consistent with the pending bits, not a popcount.
- Read: REG port i = array[SRC_i], combinational. Ports are independent and may alias.
- Write: WB_EN=1 writes RESULT_WB to array[DEST_WB] at the rising edge.
- Scoreboard next-state per register r, in priority order:
  - FLUSH=1: pending[r]←0 for all r. Overrides ISSUE_EN. A WB in the same cycle still writes data.
  - ISSUE_EN && DEST_ISSUE==r: pending[r]←1. Wins over a same-cycle WB clear of the same r, because the new producer is younger.
  - WB_EN && DEST_WB==r: pending[r]←0.
  - Otherwise hold.
- WB to a non-pending register writes data; pending stays 0 and the count is unchanged.
- ISSUE to an already-pending register leaves pending at 1 and the count unchanged.
- PENDING_CNT: next value = popcount of next pending vector, computed incrementally (+1 set, −1 clear, ±0 for issue+clear on different regs; FLUSH → 0). It never wraps: the maximum is 2**ADDR_W.
- HAZARD_i = pending[SRC_i], combinational, subject to the bypass masking below.

## Timing
- Reset (rst_n=0, asynchronous): all array entries 0, all pending 0, PENDING_CNT=0. Therefore REG=0 and HAZARD=0 while reset is held.
- Reset asserted mid-operation: the same-edge WB/ISSUE is discarded. State is valid on the first rising edge after rst_n deasserts.
- Write latency: data written at edge N is visible on REG after edge N (next cycle). The exception is the bypass, see Configuration.
- Issue→hazard latency: ISSUE_EN in cycle N raises HAZARD for a matching SRC from cycle N+1.
- WB→hazard clear: pending clears at the edge ending the WB cycle. Same-cycle behaviour depends on the bypass.
- PENDING_CNT updates on the same edge as the pending bits.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined:
  - When WB_EN && DEST_WB==SRC_i, REG port i returns RESULT_WB combinationally in the same cycle.
  - HAZARD_i is masked to 0 in that cycle, unless ISSUE_EN && DEST_ISSUE==SRC_i is also asserted in that cycle.
- Undefined:
  - REG returns the old array value during the WB cycle.
  - HAZARD_i stays 1 until the cycle after WB.
  - The hazard unit must then stall one extra cycle.

## Test plan
- Reset: write R3=0xDEADBEEF, mark R5 pending, pull rst_n low mid-cycle → immediately REG=0 for all SRC, HAZARD=0, PENDING_CNT=0.
- Write/read across ports (NUM_RD=3): write R1=0x11, R2=0x22 on successive edges, then SRC={1,2,1} → REG={0x11,0x22,0x11}.
- Scoreboard: ISSUE R4 in cycle 0 → SRC0=4 gives HAZARD[0]=1 and PENDING_CNT=1 from cycle 1. WB R4=0x44 in cycle 3: with REGFILE_BYPASS_EN, REG0=0x44 and HAZARD[0]=0 in cycle 3; without it, REG0=0 and HAZARD[0]=1 in cycle 3, then 0x44 and 0 in cycle 4.
- Simultaneous ISSUE R7 and WB R7=0x77 in one cycle → next cycle array[7]=0x77, pending[7]=1, PENDING_CNT unchanged from a prior pending R7.
- Flush: ISSUE R1, R2, R3 on three edges (PENDING_CNT=3), then FLUSH with ISSUE R9 and WB R2=0x5 → next cycle PENDING_CNT=0, all HAZARD=0, array[2]=0x5.
- Full scoreboard (ADDR_W=4): issue all 16 registers → PENDING_CNT=16 with no wrap. Then WB one register per cycle → count decrements to 0.
